// File: rtl/serial_adder_4.sv
// serial_adder_4: bit-serial adder driving a single 1-bit full-adder cell.
// Latches A/B/Cin on an accepted start, adds one bit per clock LSB first,
// and shifts each sum bit into S from the MSB end. start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed overflow output V.

module fa_1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             V,
`endif
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic             last_s;

    // The single full-adder cell consumes the operand LSBs and the running carry.
    fa_1 u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    assign last_s = (cnt_r == CW'(WIDTH - 1));

    // Next-state decode for the IDLE -> ADD -> DONE -> IDLE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ADD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ADD;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == ST_ADD);
            done    <= (state_s == ST_DONE);
        end
    end

    // Operand shifters, carry, bit counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            S       <= {WIDTH{1'b0}};
            Cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            V       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Cout (and V) keep the previous result until the add completes.
                    if (start) begin
                        a_sh_r  <= A;
                        b_sh_r  <= B;
                        carry_r <= Cin;
                        cnt_r   <= {CW{1'b0}};
                        S       <= {WIDTH{1'b0}};
                    end else begin
                        a_sh_r  <= a_sh_r;
                    end
                end
                ST_ADD: begin
                    S       <= {fa_sum_s, S[WIDTH-1:1]};
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        Cout <= fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB xor carry out of the MSB.
                        V    <= fa_cout_s ^ carry_r;
`endif
                    end else begin
                        Cout <= Cout;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end
endmodule
